// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_e  - fetch FSM states
//   FAULT_*        - encodings driven on fault_code
//   NOP_INSTR_DEF  - default word presented when no instruction is held
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,   // ready to launch a request from pc
    ST_REQ,    // request outstanding, result will be kept
    ST_HOLD,   // captured word waiting for decode
    ST_DROP,   // request outstanding, result will be discarded
    ST_FAULT   // sticky fault, only a flush leaves
  } fetch_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  // A word address must have its two low bits clear when checking is enabled.
  function automatic logic pc_misaligned(input logic [31:0] addr, input bit chk_en);
    return chk_en && (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_ack_timer.sv
// ack_timer: counts cycles a memory request has waited for its ack.
//   clock, reset_n - clock, async active-low reset
//   clear_i        - restart the count at 0 (a new request is launched)
//   enable_i       - count this cycle (request waiting, no ack)
//   expired_o      - the wait has reached ACK_TIMEOUT-1 cycles
module ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(ACK_TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  // Saturates at LAST so a late redirect into DROP still sees the expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                    cnt_d = '0;
    else if (enable_i && !expired_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage between the PC register and decode.
//   clock, reset_n            - clock, async active-low reset
//   pc                        - current PC from the PC register
//   flush                     - redirect, discards in-flight and held work
//   fetch_stall               - 1 = next-PC mux holds pc
//   imem_req/imem_addr        - memory request, held until imem_ack
//   imem_ack/imem_rdata       - memory response
//   instr/instr_pc/instr_valid- captured word to decode, held until instr_ready
//   instr_ready               - decode accepts
//   fault_code                - 00 none, 01 misaligned, 10 ack timeout (sticky)
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEF,
  parameter bit          CHECK_ALIGN = 1'b1,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        fetch_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [1:0]  fault_code
);

  fetch_state_e state_q, state_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         vld_q, vld_d;
  logic [1:0]   fault_q, fault_d;
  logic         launch;
  logic         waiting;
  logic         tmo;

  // Both REQ and DROP are waiting on the same outstanding request.
  assign waiting = (state_q == ST_REQ) || (state_q == ST_DROP);

  ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_i   (launch),
    .enable_i  (waiting && !imem_ack),
    .expired_o (tmo)
  );

  // The PC may advance only in the cycle a kept word is captured.
  assign fetch_stall = !((state_q == ST_REQ) && imem_ack && !flush);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    fault_d = fault_q;
    launch  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!flush) launch = 1'b1;
      end
      ST_REQ: begin
        if (flush && imem_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (flush) begin
          // request cannot be withdrawn; wait for its ack and discard it
          state_d = ST_DROP;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          ipc_d   = addr_q;
          vld_d   = 1'b1;
          req_d   = 1'b0;
          state_d = ST_HOLD;
        end else if (tmo) begin
          req_d   = 1'b0;
          fault_d = FAULT_TIMEOUT;
          state_d = ST_FAULT;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          vld_d   = 1'b0;
          instr_d = NOP_INSTR;
          state_d = ST_IDLE;
        end else if (instr_ready) begin
          vld_d   = 1'b0;
          instr_d = NOP_INSTR;
          launch  = 1'b1;   // back-to-back fetch from the advanced pc
        end
      end
      ST_DROP: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (tmo) begin
          req_d   = 1'b0;
          fault_d = FAULT_TIMEOUT;
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (flush) begin
          fault_d = FAULT_NONE;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      if (pc_misaligned(pc, CHECK_ALIGN)) begin
        fault_d = FAULT_MISALIGN;
        state_d = ST_FAULT;
      end else begin
        addr_d  = pc;
        req_d   = 1'b1;
        state_d = ST_REQ;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      ipc_q   <= '0;
      vld_q   <= 1'b0;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = vld_q;
  assign fault_code  = fault_q;

endmodule
